// File: rtl/timer_keypad_entry_pkg.sv
// timer_keypad_entry_pkg: shared constants and FSM state encoding for the microwave timer keypad front end
package timer_keypad_entry_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam logic [15:0] QUICK_START_VALUE = 16'h0030;
  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE, CANCEL, DONE} state_t;
endpackage

// File: rtl/timer_keypad_entry_bcd_entry_shifter.sv
// bcd_entry_shifter: MM:SS digit buffer with shift-in at digit0, clear, preset and saturating entry count
//  ports: clock/clear (async reset), shift+digit (append digit), zero (clear buffer),
//         preset+preset_value (load whole buffer), digits (buffer), count (digits entered)
module bcd_entry_shifter
  import timer_keypad_entry_pkg::*;
#(
  parameter int N = NUM_DIGITS,
  parameter int W = DIGIT_W
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         shift,
  input  logic [W-1:0] digit,
  input  logic         zero,
  input  logic         preset,
  input  logic [N*W-1:0] preset_value,
  output logic [N*W-1:0] digits,
  output logic [2:0]   count
);
  localparam logic [2:0] FULL = 3'(N);
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      digits <= '0;
      count <= '0;
    end else if (zero) begin
      digits <= '0;
      count <= '0;
    end else if (preset) begin
      digits <= preset_value;
      count <= '0;
    end else if (shift && count < FULL) begin
      digits <= {digits[(N-1)*W-1:0], digit};
      count <= count + 3'd1;
    end
endmodule

// File: rtl/timer_keypad_entry.sv
// timer_keypad_entry: keypad front end collecting MM:SS digits and sequencing load/clear/enable of the counter chain
//  ports: clock, clear (async reset), key_valid/key_code, key_start, key_stop, timer_zero in;
//         digits_out, loadn, cnt_clearn, enable, entry_count, done, err out (all registered)
//  config: define TIMER_QUICK_START_EN to make start in IDLE load 00:30 and run
module timer_keypad_entry
  import timer_keypad_entry_pkg::*;
#(
  parameter int NUM_DIGITS = timer_keypad_entry_pkg::NUM_DIGITS,
  parameter int DIGIT_W = timer_keypad_entry_pkg::DIGIT_W
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic                          key_start,
  input  logic                          key_stop,
  input  logic                          timer_zero,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
  output logic                          loadn,
  output logic                          cnt_clearn,
  output logic                          enable,
  output logic [2:0]                    entry_count,
  output logic                          done,
  output logic                          err
);
`ifdef TIMER_QUICK_START_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif
  state_t state, next;
  logic reject;
  logic take_digit;
  logic [DIGIT_W-1:0] sec_tens;
  assign sec_tens = digits_out[2*DIGIT_W-1:DIGIT_W];
  // start and stop outrank a digit arriving in the same cycle
  assign take_digit = key_valid && key_code <= DIGIT_W'(BCD_MAX) && !key_stop && !key_start;
  always_comb begin
    next = state;
    reject = 1'b0;
    case (state)
      IDLE:
        if (QUICK && key_start && !key_stop) next = LOAD;
        else if (take_digit) next = ENTRY;
      ENTRY:
        if (key_stop) next = IDLE;
        else if (key_start) begin
          if (sec_tens > DIGIT_W'(SEC_TENS_MAX)) reject = 1'b1;
          else next = LOAD;
        end
      LOAD: next = RUN;
      RUN:
        if (timer_zero) next = DONE;
        else if (key_stop) next = PAUSE;
      PAUSE:
        if (key_stop) next = CANCEL;
        else if (key_start) next = RUN;
      CANCEL: next = IDLE;
      DONE: next = (key_valid || key_start || key_stop) ? CANCEL : DONE;
      default: next = IDLE;
    endcase
  end
  bcd_entry_shifter #(.N(NUM_DIGITS), .W(DIGIT_W)) u_shifter (
    .clock        (clock),
    .clear        (clear),
    .shift        ((state == IDLE || state == ENTRY) && take_digit),
    .digit        (key_code),
    .zero         ((state == ENTRY && key_stop) || next == CANCEL),
    .preset       (QUICK && state == IDLE && key_start && !key_stop),
    .preset_value ((NUM_DIGITS*DIGIT_W)'(QUICK_START_VALUE)),
    .digits       (digits_out),
    .count        (entry_count)
  );
  // controls are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      state <= IDLE;
      loadn <= 1'b1;
      cnt_clearn <= 1'b1;
      enable <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= next;
      loadn <= next != LOAD;
      cnt_clearn <= next != CANCEL;
      enable <= next == RUN;
      done <= next == DONE;
      err <= reject;
    end
endmodule

// File: tb/tb_timer_keypad_entry.sv
// tb_timer_keypad_entry: table-driven directed check of the keypad entry FSM plus reset and quick-start sequences
module tb_timer_keypad_entry;
  logic clock = 1'b0;
  logic clear;
  logic key_valid, key_start, key_stop, timer_zero;
  logic [3:0] key_code;
  logic [15:0] digits_out;
  logic loadn, cnt_clearn, enable, done, err;
  logic [2:0] entry_count;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic v;
    logic [3:0] code;
    logic st;
    logic sp;
    logic tz;
    logic [15:0] d;
    logic ld;
    logic cl;
    logic en;
    logic [2:0] cnt;
    logic dn;
    logic er;
  } vec_t;
  vec_t vecs[$];

  timer_keypad_entry dut (
    .clock       (clock),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_start   (key_start),
    .key_stop    (key_stop),
    .timer_zero  (timer_zero),
    .digits_out  (digits_out),
    .loadn       (loadn),
    .cnt_clearn  (cnt_clearn),
    .enable      (enable),
    .entry_count (entry_count),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] d, input logic ld, input logic cl,
                       input logic en, input logic [2:0] cnt, input logic dn, input logic er);
    logic [23:0] act, exp;
    act = {digits_out, loadn, cnt_clearn, enable, entry_count, done, err};
    exp = {d, ld, cl, en, cnt, dn, er};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got digits=%h loadn=%b clrn=%b en=%b cnt=%0d done=%b err=%b, want digits=%h loadn=%b clrn=%b en=%b cnt=%0d done=%b err=%b",
               name, digits_out, loadn, cnt_clearn, enable, entry_count, done, err, d, ld, cl, en, cnt, dn, er);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] code, input logic st, input logic sp, input logic tz);
    key_valid = v;
    key_code = code;
    key_start = st;
    key_stop = sp;
    timer_zero = tz;
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    key_code = 4'd0;
    key_start = 1'b0;
    key_stop = 1'b0;
    timer_zero = 1'b0;
  endtask

  initial begin
    //          v  code  st sp tz  digits    ld cl en cnt dn er
    vecs.push_back('{1, 4'd1, 0, 0, 0, 16'h0001, 1, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{1, 4'd3, 0, 0, 0, 16'h0013, 1, 1, 0, 3'd2, 0, 0});
    vecs.push_back('{1, 4'd0, 0, 0, 0, 16'h0130, 1, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 1, 0, 0, 16'h0130, 0, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0130, 1, 1, 1, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 1, 0, 16'h0130, 1, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 1, 0, 0, 16'h0130, 1, 1, 1, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 1, 0, 16'h0130, 1, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 1, 0, 16'h0000, 1, 0, 0, 3'd0, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0000, 1, 1, 0, 3'd0, 0, 0});
    vecs.push_back('{1, 4'd1, 0, 0, 0, 16'h0001, 1, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{1, 4'd2, 0, 0, 0, 16'h0012, 1, 1, 0, 3'd2, 0, 0});
    vecs.push_back('{1, 4'd3, 0, 0, 0, 16'h0123, 1, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{1, 4'd4, 0, 0, 0, 16'h1234, 1, 1, 0, 3'd4, 0, 0});
    vecs.push_back('{1, 4'd5, 0, 0, 0, 16'h1234, 1, 1, 0, 3'd4, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 1, 0, 16'h0000, 1, 1, 0, 3'd0, 0, 0});
    vecs.push_back('{1, 4'd11, 0, 0, 0, 16'h0000, 1, 1, 0, 3'd0, 0, 0});
    vecs.push_back('{1, 4'd1, 0, 0, 0, 16'h0001, 1, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{1, 4'd7, 0, 0, 0, 16'h0017, 1, 1, 0, 3'd2, 0, 0});
    vecs.push_back('{1, 4'd5, 0, 0, 0, 16'h0175, 1, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 1, 0, 0, 16'h0175, 1, 1, 0, 3'd3, 0, 1});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0175, 1, 1, 0, 3'd3, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 1, 0, 16'h0000, 1, 1, 0, 3'd0, 0, 0});
    vecs.push_back('{1, 4'd2, 0, 0, 0, 16'h0002, 1, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 1, 0, 0, 16'h0002, 0, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0002, 1, 1, 1, 3'd1, 0, 0});
    vecs.push_back('{1, 4'd9, 0, 0, 0, 16'h0002, 1, 1, 1, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 1, 16'h0002, 1, 1, 0, 3'd1, 1, 0});
    vecs.push_back('{0, 4'd0, 1, 0, 0, 16'h0000, 1, 0, 0, 3'd0, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0000, 1, 1, 0, 3'd0, 0, 0});
    vecs.push_back('{1, 4'd4, 0, 0, 0, 16'h0004, 1, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 1, 0, 0, 16'h0004, 0, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0004, 1, 1, 1, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 1, 0, 16'h0004, 1, 1, 0, 3'd1, 0, 0});
    vecs.push_back('{0, 4'd0, 1, 1, 0, 16'h0000, 1, 0, 0, 3'd0, 0, 0});
    vecs.push_back('{0, 4'd0, 0, 0, 0, 16'h0000, 1, 1, 0, 3'd0, 0, 0});

    clear = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    key_start = 1'b0;
    key_stop = 1'b0;
    timer_zero = 1'b0;
    @(posedge clock);
    #1;
    check("reset", 16'h0000, 1, 1, 0, 3'd0, 0, 0);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].code, vecs[i].st, vecs[i].sp, vecs[i].tz);
      check($sformatf("vec%0d", i), vecs[i].d, vecs[i].ld, vecs[i].cl, vecs[i].en, vecs[i].cnt, vecs[i].dn, vecs[i].er);
    end

    step(1, 4'd3, 0, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    check("run_before_clear", 16'h0003, 1, 1, 1, 3'd1, 0, 0);
    #2;
    clear = 1'b1;
    #1;
    check("async_clear", 16'h0000, 1, 1, 0, 3'd0, 0, 0);
    @(negedge clock);
    clear = 1'b0;
    step(1, 4'd5, 0, 0, 0);
    check("idle_after_clear", 16'h0005, 1, 1, 0, 3'd1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    check("stop_after_clear", 16'h0000, 1, 1, 0, 3'd0, 0, 0);

    step(0, 4'd0, 1, 0, 0);
`ifdef TIMER_QUICK_START_EN
    check("quick_start_load", 16'h0030, 0, 1, 0, 3'd0, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    check("quick_start_run", 16'h0030, 1, 1, 1, 3'd0, 0, 0);
`else
    check("idle_start_ignored", 16'h0000, 1, 1, 0, 3'd0, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    check("idle_start_still_idle", 16'h0000, 1, 1, 0, 3'd0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
